// File: rtl/ram_scanner.sv
// ram_scanner: reads n_entries words from a synchronous RAM starting at
// address 0. Each word is presented on data_out with valid high for
// HOLD_CYCLES cycles.
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset_n    - asynchronous active-low reset
//   start      - begin a scan (sampled only while idle)
//   abort      - abandon an active scan (no done pulse)
//   n_entries  - number of words to read, 0..2^ADDR_W, captured on start
//   rd_data    - RAM read data, valid one cycle after addr/re
//   addr, re   - RAM read address and read enable
//   data_out   - word currently presented (holds last value when idle)
//   valid      - data_out is being presented
//   busy       - a scan is in progress
//   done       - single-cycle pulse at the normal end of a scan
module ram_scanner #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   n_entries,
  input  logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] addr,
  output logic              re,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0]   HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]   CntOne   = CntW'(1);
  localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LenOne   = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StLatch = 3'd2,
    StHold  = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;

  logic hold_last;
  logic last_word;
  logic active;

  assign hold_last = (hold_cnt_q == HoldLast);
  // Length is one bit wider than addr so a full-RAM scan ends at all-ones
  // without addr ever wrapping.
  assign last_word = ({1'b0, addr_q} + LenOne) == len_q;
  assign active    = (state_q == StRead) || (state_q == StLatch) || (state_q == StHold);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      len_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (n_entries != '0) ? StRead : StDone;
        end
      end
      StRead:  state_d = StLatch;
      StLatch: state_d = StHold;
      StHold: begin
        if (hold_last) begin
          state_d = last_word ? StDone : StRead;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Abort overrides every transition of an active scan.
    if (abort && active) begin
      state_d = StIdle;
    end
  end

  // Datapath next-state logic
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    len_d      = len_q;
    addr_d     = addr_q;
    data_d     = data_q;
    case (state_q)
      StIdle: begin
        if (start && (n_entries != '0)) begin
          addr_d = '0;
          len_d  = n_entries;
        end
      end
      StLatch: begin
        data_d     = rd_data;
        hold_cnt_d = '0;
      end
      StHold: begin
        hold_cnt_d = hold_cnt_q + CntOne;
        if (hold_last && !last_word) begin
          addr_d = addr_q + AddrOne;
        end
      end
      default: ;
    endcase
    if (abort && active) begin
      hold_cnt_d = hold_cnt_q;
      data_d     = data_q;
      addr_d     = '0;
    end
  end

  // Outputs decoded from the present state
  always_comb begin
    re       = (state_q == StRead);
    valid    = (state_q == StHold);
    done     = (state_q == StDone);
    busy     = (state_q != StIdle);
    addr     = addr_q;
    data_out = data_q;
  end

endmodule

// File: tb/tb_ram_scanner.sv
module tb_ram_scanner;

  localparam int unsigned AW   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned HOLD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW:0]   n_entries = '0;
  logic [DW-1:0] rd_data = '0;
  logic [AW-1:0] addr;
  logic          re;
  logic [DW-1:0] data_out;
  logic          valid;
  logic          busy;
  logic          done;

  ram_scanner #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .n_entries (n_entries),
    .rd_data   (rd_data),
    .addr      (addr),
    .re        (re),
    .data_out  (data_out),
    .valid     (valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM model
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (re) rd_data <= mem[addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] addr;
  } word_t;

  word_t exp_words[$];
  int    exp_done[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic [AW-1:0] a);
    word_t w;
    w.data = d;
    w.addr = a;
    exp_words.push_back(w);
  endtask

  // Issue a start pulse; done_off < 0 means no done pulse is expected.
  task automatic do_start(input logic [AW:0] n, input int done_off, output int t);
    @(negedge clk);
    start     = 1'b1;
    n_entries = n;
    t         = cyc;
    if (done_off >= 0) exp_done.push_back(t + done_off);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("idle_timeout");
  endtask

  // Monitor: compares each presented word, hold length, re width and done timing.
  initial begin
    logic valid_p = 1'b0;
    logic re_p    = 1'b0;
    int   vrun    = 0;
    int   rerun   = 0;
    word_t w;
    int   dexp;
    forever begin
      @(negedge clk);
      if (valid && !valid_p) begin
        if (exp_words.size() == 0) begin
          fail_now("word_unexpected");
        end else begin
          w = exp_words.pop_front();
          chk("word_data", data_out, w.data);
          chk("word_addr", addr, w.addr);
        end
        vrun = 1;
      end else if (valid) begin
        vrun++;
      end
      // Normal HOLD exit goes to READ or DONE; abort/reset exits are skipped.
      if (!valid && valid_p && (re || done)) chk("hold_len", vrun, HOLD);
      if (re && !re_p) rerun = 1;
      else if (re) rerun++;
      if (!re && re_p) chk("re_len", rerun, 1);
      if (done) begin
        if (exp_done.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          dexp = exp_done.pop_front();
          chk("done_cycle", cyc, dexp);
        end
      end
      valid_p = valid;
      re_p    = re;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 16; i++) mem[i] = DW'(i);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_re", re, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;

    // Three-word scan; n_entries changed after acceptance must not matter
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33;
    push_word(8'h11, 0); push_word(8'h22, 1); push_word(8'h33, 2);
    do_start(3, 19, t);
    n_entries = 7;
    chk("first_re", re, 1);
    chk("first_addr", addr, 0);
    wait_idle();

    // Zero-length scan; abort during DONE has no effect
    do_start(0, 1, t);
    chk("n0_busy", busy, 1);
    chk("n0_re", re, 0);
    chk("n0_valid", valid, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("n0_busy_after", busy, 0);

    // Start and abort together in IDLE: start wins
    mem[0] = 8'h40; mem[1] = 8'h41;
    push_word(8'h40, 0); push_word(8'h41, 1);
    abort = 1'b1;
    do_start(2, 13, t);
    abort = 1'b0;
    wait_idle();

    // Full RAM scan
    for (int i = 0; i < 16; i++) begin
      mem[i] = DW'(i);
      push_word(DW'(i), AW'(i));
    end
    do_start(16, 97, t);
    wait_idle();
    chk("full_addr_end", addr, 15);

    // Start re-pulsed during HOLD with a different length is ignored
    mem[0] = 8'hA1; mem[1] = 8'hB2; mem[2] = 8'hC3; mem[3] = 8'hD4; mem[4] = 8'hE5;
    push_word(8'hA1, 0); push_word(8'hB2, 1); push_word(8'hC3, 2);
    do_start(3, 19, t);
    wait_cyc(t + 4);
    chk("restart_in_hold", valid, 1);
    start = 1'b1;
    n_entries = 5;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Abort on the second HOLD cycle of word 1
    mem[0] = 8'h5A; mem[1] = 8'h6B; mem[2] = 8'h7C;
    push_word(8'h5A, 0); push_word(8'h6B, 1);
    do_start(3, -1, t);
    wait_cyc(t + 10);
    chk("abort_pre_valid", valid, 1);
    chk("abort_pre_addr", addr, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data_out", data_out, 8'h6B);
    chk("abort_addr", addr, 0);
    repeat (15) @(negedge clk);
    chk("abort_stays_idle", busy, 0);

    // Asynchronous reset mid-HOLD, then a fresh one-word scan
    mem[0] = 8'h91; mem[1] = 8'h92; mem[2] = 8'h93;
    push_word(8'h91, 0);
    do_start(3, -1, t);
    wait_cyc(t + 4);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_addr", addr, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_re", re, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    repeat (2) @(negedge clk);
    mem[0] = 8'h99;
    push_word(8'h99, 0);
    reset_n   = 1'b1;
    start     = 1'b1;
    n_entries = 1;
    t         = cyc;
    exp_done.push_back(t + 7);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    chk("words_left", exp_words.size(), 0);
    chk("dones_left", exp_done.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
